reg_wb_ctrl: RTL

//  Write-back controller driving the single write port of the 16x32 register file (rd_addr/rd_data/w_en).

---
 rtl/reg_wb_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/reg_wb_ctrl.sv
// rtl/reg_wb_ctrl.sv - register file write-back arbiter with load queue and busy scoreboard; optional macro REG_WB_FORWARD_EN
module reg_wb_ctrl #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 4,
    parameter int LDQ_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    input  logic [ADDR_W-1:0]    alu_rd,
    input  logic [DATA_W-1:0]    alu_data,
    output logic                 alu_ready,
    input  logic                 ld_valid,
    input  logic [ADDR_W-1:0]    ld_rd,
    input  logic [DATA_W-1:0]    ld_data,
    output logic                 ld_ready,
    input  logic                 iss_valid,
    input  logic [ADDR_W-1:0]    iss_rd,
    output logic [2**ADDR_W-1:0] busy,
`ifdef REG_WB_FORWARD_EN
    input  logic [ADDR_W-1:0]    rn_addr,
    input  logic [ADDR_W-1:0]    rm_addr,
    output logic                 rn_fwd_hit,
    output logic                 rm_fwd_hit,
    output logic [DATA_W-1:0]    fwd_data,
`endif
    output logic                 wb_en,
    output logic [ADDR_W-1:0]    wb_addr,
    output logic [DATA_W-1:0]    wb_data
);

    localparam int PTR_W = $clog2(LDQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 2**ADDR_W;

    logic [ADDR_W-1:0] ldq_rd   [LDQ_DEPTH];
    logic [DATA_W-1:0] ldq_data [LDQ_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic              ldq_full;
    logic              ldq_empty;
    logic              enq;
    logic              deq;
    logic              sel_alu;
    logic              sel_ldq;
    logic              sel_valid;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;
    logic              clr_valid;
    logic [ADDR_W-1:0] clr_addr;
    logic [NREG-1:0]   busy_next;

    // Source arbitration: a full queue must drain first so loads never block forever
    always_comb begin
        ldq_full  = (count == CNT_W'(LDQ_DEPTH));
        ldq_empty = (count == '0);
        sel_alu   = alu_valid & ~ldq_full;
        sel_ldq   = ldq_full | (~alu_valid & ~ldq_empty);
        sel_valid = sel_alu | sel_ldq;
        sel_rd    = sel_ldq ? ldq_rd[rd_ptr]   : alu_rd;
        sel_data  = sel_ldq ? ldq_data[rd_ptr] : alu_data;
        enq       = ld_valid & ~ldq_full;
        deq       = sel_ldq;
        alu_ready = ~ldq_full;
        ld_ready  = ~ldq_full;
    end

    // Load queue storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (enq) begin
            ldq_rd[wr_ptr]   <= ld_rd;
            ldq_data[wr_ptr] <= ld_data;
        end
    end

    // Load queue pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
            if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({enq, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Registered write port; address/data hold when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
        end else begin
            wb_en <= sel_valid;
            if (sel_valid) begin
                wb_addr <= sel_rd;
                wb_data <= sel_data;
            end
        end
    end

    // Scoreboard clear point: early when the write can be forwarded, else once the file holds it
    always_comb begin
`ifdef REG_WB_FORWARD_EN
        clr_valid = sel_valid;
        clr_addr  = sel_rd;
`else
        clr_valid = wb_en;
        clr_addr  = wb_addr;
`endif
        busy_next = busy;
        if (clr_valid) busy_next[clr_addr] = 1'b0;
        if (iss_valid) busy_next[iss_rd]   = 1'b1;
    end

    // Scoreboard register; a new issue overrides a same-cycle commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy <= '0;
        else     busy <= busy_next;
    end

`ifdef REG_WB_FORWARD_EN
    // Bypass of the write currently being presented to the register file
    always_comb begin
        rn_fwd_hit = wb_en & (rn_addr == wb_addr);
        rm_fwd_hit = wb_en & (rm_addr == wb_addr);
        fwd_data   = wb_data;
    end
`endif

endmodule
